// File: rtl/mul_arbiter_pkg.sv
// Shared types and constants for the multiplier arbiter.
package mul_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_M,
    S_LOAD_Q,
    S_WAIT,
    S_RESP
  } state_e;

  localparam logic [7:0] IDLE_BUS    = 8'h00;
  localparam int         DEF_N_REQ   = 4;
  localparam int         DEF_TIMEOUT = 64;

endpackage

// File: rtl/mul_arbiter_if.sv
// Requester-side bus: operand pairs in, one-hot accept and response out.
interface mul_arbiter_if
  import mul_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ
);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_opa;
  logic [8*N_REQ-1:0] req_opb;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ-1:0]   rsp_valid;
  logic [15:0]        rsp_prod;
  logic               rsp_err;

  modport master (
    output req_valid, req_opa, req_opb,
    input  req_ready, rsp_valid, rsp_prod, rsp_err
  );

  modport slave (
    input  req_valid, req_opa, req_opb,
    output req_ready, rsp_valid, rsp_prod, rsp_err
  );
endinterface

// File: rtl/mul_arbiter_rr_picker.sv
// Round-robin picker: first set request after ptr, wrapping modulo N_REQ.
module rr_picker
  import mul_arb_pkg::*;
#(
  parameter  int N_REQ = DEF_N_REQ,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      pos = (int'(ptr) + i) % N_REQ;
      if (!any && req[pos]) begin
        any        = 1'b1;
        idx        = IDX_W'(pos);
        grant[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one Booth multiplier among N_REQ requesters; sequences the
// bgn/inbus load, waits for done (with watchdog) and returns the product.
//
// state  | meaning
// IDLE   | arbitrate, accept one operand pair
// LOAD_M | bgn high, multiplicand on inbus
// LOAD_Q | multiplier on inbus, clear watchdog
// WAIT   | wait for done or watchdog expiry
// RESP   | one-cycle response to the granted requester
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_b,
  mul_arbiter_if.slave      req_if,
  output logic              busy,
  output logic              mul_bgn,
  output logic [7:0]        mul_inbus,
  input  logic              mul_done,
  input  logic [16:0]       mul_outbus
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(N_REQ - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   id_q, id_d;
  logic [7:0]         opa_q, opa_d;
  logic [7:0]         opb_q, opb_d;
  logic [15:0]        prod_q, prod_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [N_REQ-1:0]   pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               unused_sign;

  // Bit 16 is only the sign extension of the product.
  assign unused_sign = mul_outbus[16];

  rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req   (req_if.req_valid),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign busy = (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= S_IDLE;
      ptr_q   <= PTR_RST;
      id_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      prod_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      prod_q  <= prod_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    ptr_d            = ptr_q;
    id_d             = id_q;
    opa_d            = opa_q;
    opb_d            = opb_q;
    prod_d           = prod_q;
    err_d            = err_q;
    cnt_d            = cnt_q;
    req_if.req_ready = '0;
    req_if.rsp_valid = '0;
    req_if.rsp_prod  = '0;
    req_if.rsp_err   = 1'b0;
    mul_bgn          = 1'b0;
    mul_inbus        = IDLE_BUS;

    unique case (state_q)
      S_IDLE: begin
        // Gated by rst_b so nothing is accepted while reset is held.
        if (rst_b && pick_any) begin
          req_if.req_ready = pick_grant;
          opa_d   = req_if.req_opa[{pick_idx, 3'b000} +: 8];
          opb_d   = req_if.req_opb[{pick_idx, 3'b000} +: 8];
          id_d    = pick_idx;
          state_d = S_LOAD_M;
        end
      end
      S_LOAD_M: begin
        mul_bgn   = 1'b1;
        mul_inbus = opa_q;
        state_d   = S_LOAD_Q;
      end
      S_LOAD_Q: begin
        mul_inbus = opb_q;
        cnt_d     = '0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mul_done) begin
          prod_d  = mul_outbus[15:0];
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          prod_d  = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        req_if.rsp_valid[id_q] = rst_b;
        req_if.rsp_prod        = prod_q;
        req_if.rsp_err         = err_q;
        ptr_d                  = id_q;
        state_d                = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
